// File: rtl/axi4_s_bus_wr_fifos_param_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : axi4_s_bus_wr_fifos_param_if
// Purpose  : Bundles the AXI4 slave write-path signals (AW/W/B) and the
//            core-side FIFO access signals of axi4_s_bus_wr_fifos_param.
// Modports : slave  - the buffer block (accepts AXI writes, serves the core)
//            master - the environment (AXI master plus core write engine)
// Signals  : s_aw*/s_w*/s_b*         AXI4 slave channel handshakes + payloads
//            aw_rd_*/w_rd_*/b_wr_*   core-side FIFO pop/push ports
//            aw_count/w_count        FIFO occupancies
//            outstanding             accepted AW not yet answered on B
//            burst_ready             AW head present and a full burst buffered
//            err_b_overflow          sticky B FIFO overflow flag
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface axi4_s_bus_wr_fifos_param_if #(
    parameter int AW_W     = 64,
    parameter int W_W      = 37,
    parameter int B_W      = 6,
    parameter int AW_DEPTH = 4,
    parameter int W_DEPTH  = 16
);
    // AXI AW channel
    logic                             s_awvalid;
    logic                             s_awready;
    logic [AW_W-1:0]                  s_aw_flat_in;
    // AXI W channel
    logic                             s_wvalid;
    logic                             s_wready;
    logic [W_W-1:0]                   s_w_flat_in;
    logic                             s_wlast;
    // AXI B channel
    logic                             s_bvalid;
    logic                             s_bready;
    logic [B_W-1:0]                   s_b_flat_out;
    // Core-side AW read port
    logic                             aw_rd_en;
    logic [AW_W-1:0]                  aw_rd_data;
    logic                             aw_rd_empty;
    // Core-side W read port
    logic                             w_rd_en;
    logic [W_W-1:0]                   w_rd_data;
    logic                             w_rd_last;
    logic                             w_rd_empty;
    logic                             burst_ready;
    // Core-side B write port
    logic                             b_wr_en;
    logic [B_W-1:0]                   b_wr_data;
    logic                             b_wr_full;
    // Status
    logic [$clog2(AW_DEPTH+1)-1:0]    aw_count;
    logic [$clog2(W_DEPTH+1)-1:0]     w_count;
    logic [7:0]                       outstanding;
    logic                             err_b_overflow;

    modport slave (
        input  s_awvalid, s_aw_flat_in,
        input  s_wvalid, s_w_flat_in, s_wlast,
        input  s_bready,
        input  aw_rd_en, w_rd_en, b_wr_en, b_wr_data,
        output s_awready, s_wready, s_bvalid, s_b_flat_out,
        output aw_rd_data, aw_rd_empty,
        output w_rd_data, w_rd_last, w_rd_empty, burst_ready,
        output b_wr_full,
        output aw_count, w_count, outstanding, err_b_overflow
    );

    modport master (
        output s_awvalid, s_aw_flat_in,
        output s_wvalid, s_w_flat_in, s_wlast,
        output s_bready,
        output aw_rd_en, w_rd_en, b_wr_en, b_wr_data,
        input  s_awready, s_wready, s_bvalid, s_b_flat_out,
        input  aw_rd_data, aw_rd_empty,
        input  w_rd_data, w_rd_last, w_rd_empty, burst_ready,
        input  b_wr_full,
        input  aw_count, w_count, outstanding, err_b_overflow
    );
endinterface : axi4_s_bus_wr_fifos_param_if
`default_nettype wire

// File: rtl/axi4_s_bus_wr_fifos_param.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : axi4_s_bus_wr_fifos_param
// Purpose  : AXI4 slave write-path buffer. Independent first-word-fall-through
//            FIFOs for AW, W (with WLAST) and B sit between the AXI slave port
//            and a core write engine. AW acceptance is throttled by an
//            outstanding-transaction limit, complete bursts in the W FIFO are
//            counted so the core can start a write only when address and all
//            data are present, and B overflow raises a sticky error.
// Ports    : clk    - clock
//            reset  - synchronous active-high reset
//            bus    - axi4_s_bus_wr_fifos_param_if.slave (AXI + core side)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module axi4_s_bus_wr_fifos_param #(
    parameter int AW_W            = 64,
    parameter int W_W             = 37,
    parameter int B_W             = 6,
    parameter int AW_DEPTH        = 4,
    parameter int W_DEPTH         = 16,
    parameter int B_DEPTH         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    axi4_s_bus_wr_fifos_param_if.slave     bus
);

    //--------------------------------------------------------------------------
    // Widths and typed constants
    //--------------------------------------------------------------------------
    localparam int c_AW_PW = $clog2(AW_DEPTH);
    localparam int c_AW_CW = $clog2(AW_DEPTH + 1);
    localparam int c_W_PW  = $clog2(W_DEPTH);
    localparam int c_W_CW  = $clog2(W_DEPTH + 1);
    localparam int c_B_PW  = $clog2(B_DEPTH);
    localparam int c_B_CW  = $clog2(B_DEPTH + 1);

    localparam logic [c_AW_PW-1:0] c_AW_PTR_ONE = 1;
    localparam logic [c_AW_CW-1:0] c_AW_CNT_ONE = 1;
    localparam logic [c_AW_CW-1:0] c_AW_FULL    = c_AW_CW'(AW_DEPTH);
    localparam logic [c_W_PW-1:0]  c_W_PTR_ONE  = 1;
    localparam logic [c_W_CW-1:0]  c_W_CNT_ONE  = 1;
    localparam logic [c_W_CW-1:0]  c_W_FULL     = c_W_CW'(W_DEPTH);
    localparam logic [c_B_PW-1:0]  c_B_PTR_ONE  = 1;
    localparam logic [c_B_CW-1:0]  c_B_CNT_ONE  = 1;
    localparam logic [c_B_CW-1:0]  c_B_FULL     = c_B_CW'(B_DEPTH);
    localparam logic [7:0]         c_MAX_OUT    = 8'(MAX_OUTSTANDING);
    localparam logic [7:0]         c_OUT_ONE    = 8'd1;

    //--------------------------------------------------------------------------
    // Storage and state
    //--------------------------------------------------------------------------
    logic [AW_W-1:0]    r_aw_mem [AW_DEPTH];
    logic [c_AW_PW-1:0] r_aw_wptr;
    logic [c_AW_PW-1:0] r_aw_rptr;
    logic [c_AW_CW-1:0] r_aw_cnt;

    // W entries carry WLAST in the top bit
    logic [W_W:0]       r_w_mem [W_DEPTH];
    logic [c_W_PW-1:0]  r_w_wptr;
    logic [c_W_PW-1:0]  r_w_rptr;
    logic [c_W_CW-1:0]  r_w_cnt;

    logic [B_W-1:0]     r_b_mem [B_DEPTH];
    logic [c_B_PW-1:0]  r_b_wptr;
    logic [c_B_PW-1:0]  r_b_rptr;
    logic [c_B_CW-1:0]  r_b_cnt;

    logic [7:0]         r_outstanding;
    logic [c_W_CW-1:0]  r_burst_cnt;
    logic               r_err_b_ovf;

    //--------------------------------------------------------------------------
    // Flags, handshakes, effective push/pop
    //--------------------------------------------------------------------------
    logic         w_aw_full, w_aw_empty, w_aw_push, w_aw_pop, w_awready;
    logic         w_w_full,  w_w_empty,  w_w_push,  w_w_pop,  w_wready;
    logic         w_b_full,  w_b_empty,  w_b_push,  w_b_pop;
    logic [W_W:0] w_w_head;
    logic         w_burst_in, w_burst_out;

    assign w_aw_full  = (r_aw_cnt == c_AW_FULL);
    assign w_aw_empty = (r_aw_cnt == '0);
    assign w_w_full   = (r_w_cnt == c_W_FULL);
    assign w_w_empty  = (r_w_cnt == '0);
    assign w_b_full   = (r_b_cnt == c_B_FULL);
    assign w_b_empty  = (r_b_cnt == '0);

    // AW acceptance also waits on the outstanding-transaction budget
    assign w_awready = ~reset & ~w_aw_full & (r_outstanding < c_MAX_OUT);
    assign w_wready  = ~reset & ~w_w_full;

    // Push/pop qualified by full/empty: a push into a full FIFO is dropped
    // even if a pop happens in the same cycle (no full bypass).
    assign w_aw_push = bus.s_awvalid & w_awready;
    assign w_aw_pop  = bus.aw_rd_en  & ~w_aw_empty;
    assign w_w_push  = bus.s_wvalid  & w_wready;
    assign w_w_pop   = bus.w_rd_en   & ~w_w_empty;
    assign w_b_push  = bus.b_wr_en   & ~w_b_full;
    // The B pop is exactly the AXI B handshake since s_bvalid = ~empty
    assign w_b_pop   = bus.s_bready  & ~w_b_empty;

    assign w_w_head    = r_w_mem[r_w_rptr];
    assign w_burst_in  = w_w_push & bus.s_wlast;
    assign w_burst_out = w_w_pop  & w_w_head[W_W];

    //--------------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are qualified by the counts)
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_aw_push) begin
            r_aw_mem[r_aw_wptr] <= bus.s_aw_flat_in;
        end
        if (w_w_push) begin
            r_w_mem[r_w_wptr] <= {bus.s_wlast, bus.s_w_flat_in};
        end
        if (w_b_push) begin
            r_b_mem[r_b_wptr] <= bus.b_wr_data;
        end
    end

    //--------------------------------------------------------------------------
    // AW FIFO pointers and occupancy
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aw_wptr <= '0;
            r_aw_rptr <= '0;
            r_aw_cnt  <= '0;
        end else begin
            if (w_aw_push) r_aw_wptr <= r_aw_wptr + c_AW_PTR_ONE;
            if (w_aw_pop)  r_aw_rptr <= r_aw_rptr + c_AW_PTR_ONE;
            case ({w_aw_push, w_aw_pop})
                2'b10:   r_aw_cnt <= r_aw_cnt + c_AW_CNT_ONE;
                2'b01:   r_aw_cnt <= r_aw_cnt - c_AW_CNT_ONE;
                default: r_aw_cnt <= r_aw_cnt;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // W FIFO pointers and occupancy
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_wptr <= '0;
            r_w_rptr <= '0;
            r_w_cnt  <= '0;
        end else begin
            if (w_w_push) r_w_wptr <= r_w_wptr + c_W_PTR_ONE;
            if (w_w_pop)  r_w_rptr <= r_w_rptr + c_W_PTR_ONE;
            case ({w_w_push, w_w_pop})
                2'b10:   r_w_cnt <= r_w_cnt + c_W_CNT_ONE;
                2'b01:   r_w_cnt <= r_w_cnt - c_W_CNT_ONE;
                default: r_w_cnt <= r_w_cnt;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // B FIFO pointers, occupancy and sticky overflow flag
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_wptr    <= '0;
            r_b_rptr    <= '0;
            r_b_cnt     <= '0;
            r_err_b_ovf <= 1'b0;
        end else begin
            if (w_b_push) r_b_wptr <= r_b_wptr + c_B_PTR_ONE;
            if (w_b_pop)  r_b_rptr <= r_b_rptr + c_B_PTR_ONE;
            case ({w_b_push, w_b_pop})
                2'b10:   r_b_cnt <= r_b_cnt + c_B_CNT_ONE;
                2'b01:   r_b_cnt <= r_b_cnt - c_B_CNT_ONE;
                default: r_b_cnt <= r_b_cnt;
            endcase
            if (bus.b_wr_en & w_b_full) begin
                r_err_b_ovf <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outstanding-transaction counter. A B handshake with nothing
    // outstanding is a core protocol error; it is absorbed, not wrapped.
    // MAX_OUTSTANDING <= 255 keeps the increment from overflowing.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
        end else if (w_aw_push & ~w_b_pop) begin
            r_outstanding <= r_outstanding + c_OUT_ONE;
        end else if (~w_aw_push & w_b_pop & (r_outstanding != '0)) begin
            r_outstanding <= r_outstanding - c_OUT_ONE;
        end
    end

    //--------------------------------------------------------------------------
    // Complete-burst counter: WLAST beats currently held in the W FIFO.
    // It can never exceed W_DEPTH, so its width matches the W occupancy.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else begin
            case ({w_burst_in, w_burst_out})
                2'b10:   r_burst_cnt <= r_burst_cnt + c_W_CNT_ONE;
                2'b01:   r_burst_cnt <= r_burst_cnt - c_W_CNT_ONE;
                default: r_burst_cnt <= r_burst_cnt;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.s_awready      = w_awready;
    assign bus.s_wready       = w_wready;
    assign bus.s_bvalid       = ~w_b_empty;
    assign bus.s_b_flat_out   = r_b_mem[r_b_rptr];

    assign bus.aw_rd_data     = r_aw_mem[r_aw_rptr];
    assign bus.aw_rd_empty    = w_aw_empty;
    assign bus.w_rd_data      = w_w_head[W_W-1:0];
    assign bus.w_rd_last      = w_w_head[W_W];
    assign bus.w_rd_empty     = w_w_empty;
    assign bus.burst_ready    = ~w_aw_empty & (r_burst_cnt != '0);
    assign bus.b_wr_full      = w_b_full;

    assign bus.aw_count       = r_aw_cnt;
    assign bus.w_count        = r_w_cnt;
    assign bus.outstanding    = r_outstanding;
    assign bus.err_b_overflow = r_err_b_ovf;

endmodule : axi4_s_bus_wr_fifos_param
`default_nettype wire

// File: tb/tb_axi4_s_bus_wr_fifos_param.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_axi4_s_bus_wr_fifos_param
// Purpose  : Self-checking bench. DUT A (MAX_OUTSTANDING=8) runs a directed
//            vector table plus fill / B overflow / W wrap / mid-run reset
//            sequences; DUT B (MAX_OUTSTANDING=2) runs the outstanding limit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_axi4_s_bus_wr_fifos_param;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi4_s_bus_wr_fifos_param_if #(.AW_W(64), .W_W(37), .B_W(6), .AW_DEPTH(4), .W_DEPTH(16)) ifa ();
    axi4_s_bus_wr_fifos_param_if #(.AW_W(64), .W_W(37), .B_W(6), .AW_DEPTH(4), .W_DEPTH(16)) ifb ();

    axi4_s_bus_wr_fifos_param #(
        .AW_W(64), .W_W(37), .B_W(6), .AW_DEPTH(4), .W_DEPTH(16), .B_DEPTH(4),
        .MAX_OUTSTANDING(8)
    ) u_dut_a (.clk(clk), .reset(reset), .bus(ifa));

    axi4_s_bus_wr_fifos_param #(
        .AW_W(64), .W_W(37), .B_W(6), .AW_DEPTH(4), .W_DEPTH(16), .B_DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.s_awvalid = 0; ifa.s_aw_flat_in = '0;
        ifa.s_wvalid  = 0; ifa.s_w_flat_in  = '0; ifa.s_wlast = 0;
        ifa.s_bready  = 0; ifa.aw_rd_en = 0; ifa.w_rd_en = 0;
        ifa.b_wr_en   = 0; ifa.b_wr_data = '0;
    endtask

    task automatic idle_b();
        ifb.s_awvalid = 0; ifb.s_aw_flat_in = '0;
        ifb.s_wvalid  = 0; ifb.s_w_flat_in  = '0; ifb.s_wlast = 0;
        ifb.s_bready  = 0; ifb.aw_rd_en = 0; ifb.w_rd_en = 0;
        ifb.b_wr_en   = 0; ifb.b_wr_data = '0;
    endtask

    // One row: inputs held across one clock edge, then the state expected
    // just after that edge.
    typedef struct {
        bit rst, awv, wv, wl, brdy, awp, wp, bp;
        bit awr, wr, bv;
        int awc, wc, outs;
        bit br, err;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    initial begin
        //          rst awv wv wl brdy awp wp bp | awr wr bv awc wc out br err
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0}; // in reset
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0}; // idle
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 1, 0, 0}; // AW
        tbl[3]  = '{0, 0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 1, 1, 1, 0, 0}; // beat 1
        tbl[4]  = '{0, 0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 1, 2, 1, 0, 0}; // beat 2
        tbl[5]  = '{0, 0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 1, 3, 1, 0, 0}; // beat 3
        tbl[6]  = '{0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 1, 4, 1, 1, 0}; // beat 4 WLAST
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 1, 3, 1, 1, 0}; // pop W
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 1, 2, 1, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 1, 1, 1, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 1, 0,   1, 1, 0, 0, 0, 1, 0, 0}; // pop last + AW
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 0, 0, 1, 0, 0}; // push B
        tbl[12] = '{0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0}; // B handshake
        tbl[13] = '{0, 1, 1, 1, 0, 0, 0, 0,   1, 1, 0, 1, 1, 1, 1, 0}; // AW + 1-beat burst
        tbl[14] = '{0, 1, 1, 1, 0, 0, 1, 0,   1, 1, 0, 2, 1, 2, 1, 0}; // WLAST push+pop
        tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 2, 0, 2, 0, 0}; // burst cnt now 0
        tbl[16] = '{0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 1, 0, 2, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 0, 2, 0, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 0, 0, 2, 0, 0}; // push B
        tbl[19] = '{0, 0, 0, 0, 1, 0, 0, 1,   1, 1, 1, 0, 0, 1, 0, 0}; // B push+pop
        tbl[20] = '{0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0};
        tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 0, 0, 0, 0, 0}; // stray B
        tbl[22] = '{0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0}; // no underflow
        tbl[23] = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_a();
        idle_b();
        #2;

        //---------------- table-driven vectors on DUT A ----------------
        for (int i = 0; i < NV; i++) begin
            reset            = tbl[i].rst;
            ifa.s_awvalid    = tbl[i].awv;
            ifa.s_aw_flat_in = 64'hA000 + 64'(i);
            ifa.s_wvalid     = tbl[i].wv;
            ifa.s_w_flat_in  = 37'h1000 + 37'(i);
            ifa.s_wlast      = tbl[i].wl;
            ifa.s_bready     = tbl[i].brdy;
            ifa.aw_rd_en     = tbl[i].awp;
            ifa.w_rd_en      = tbl[i].wp;
            ifa.b_wr_en      = tbl[i].bp;
            ifa.b_wr_data    = 6'(i);
            tick();
            chk($sformatf("v%0d awready", i),     64'(ifa.s_awready),      64'(tbl[i].awr));
            chk($sformatf("v%0d wready", i),      64'(ifa.s_wready),       64'(tbl[i].wr));
            chk($sformatf("v%0d bvalid", i),      64'(ifa.s_bvalid),       64'(tbl[i].bv));
            chk($sformatf("v%0d aw_count", i),    64'(ifa.aw_count),       64'(tbl[i].awc));
            chk($sformatf("v%0d w_count", i),     64'(ifa.w_count),        64'(tbl[i].wc));
            chk($sformatf("v%0d outstanding", i), 64'(ifa.outstanding),    64'(tbl[i].outs));
            chk($sformatf("v%0d burst_ready", i), 64'(ifa.burst_ready),    64'(tbl[i].br));
            chk($sformatf("v%0d err", i),         64'(ifa.err_b_overflow), 64'(tbl[i].err));
        end
        idle_a();

        //---------------- AW fill with no pops ----------------
        for (int i = 0; i < 4; i++) begin
            ifa.s_awvalid    = 1;
            ifa.s_aw_flat_in = 64'h100 + 64'(i);
            tick();
            chk($sformatf("fill%0d aw_count", i), 64'(ifa.aw_count), 64'(i + 1));
            chk($sformatf("fill%0d awready", i),  64'(ifa.s_awready), (i < 3) ? 64'd1 : 64'd0);
        end
        ifa.s_aw_flat_in = 64'h104;
        tick();
        chk("fill held aw_count", 64'(ifa.aw_count), 64'd4);
        chk("fill held outstanding", 64'(ifa.outstanding), 64'd4);
        chk("fill head", ifa.aw_rd_data, 64'h100);
        ifa.aw_rd_en = 1;
        tick();
        ifa.aw_rd_en = 0;
        chk("fill after pop aw_count", 64'(ifa.aw_count), 64'd3);
        chk("fill after pop awready", 64'(ifa.s_awready), 64'd1);
        tick();
        ifa.s_awvalid = 0;
        chk("fill 5th accepted aw_count", 64'(ifa.aw_count), 64'd4);
        chk("fill 5th outstanding", 64'(ifa.outstanding), 64'd5);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("fill order %0d", j), ifa.aw_rd_data, 64'h101 + 64'(j));
            ifa.aw_rd_en = 1;
            tick();
        end
        ifa.aw_rd_en = 0;
        chk("fill drained empty", 64'(ifa.aw_rd_empty), 64'd1);

        //---------------- B overflow and drain ----------------
        for (int i = 1; i <= 4; i++) begin
            ifa.b_wr_en = 1; ifa.b_wr_data = 6'(i);
            tick();
        end
        chk("b full", 64'(ifa.b_wr_full), 64'd1);
        chk("b no err yet", 64'(ifa.err_b_overflow), 64'd0);
        ifa.b_wr_data = 6'd5;
        tick();
        ifa.b_wr_en = 0;
        chk("b overflow err", 64'(ifa.err_b_overflow), 64'd1);
        tick();
        chk("b overflow sticky", 64'(ifa.err_b_overflow), 64'd1);
        ifa.s_bready = 1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("b drain %0d", i), 64'(ifa.s_b_flat_out), 64'(i));
            tick();
        end
        ifa.s_bready = 0;
        chk("b drained bvalid", 64'(ifa.s_bvalid), 64'd0);
        chk("b drained outstanding", 64'(ifa.outstanding), 64'd1);
        chk("b err still sticky", 64'(ifa.err_b_overflow), 64'd1);

        //---------------- W pointer wrap (20 beats) ----------------
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) begin
                ifa.s_wvalid    = 1;
                ifa.s_w_flat_in = 37'h200 + 37'(10 * r + i);
                ifa.s_wlast     = (r == 1 && i == 9);
                tick();
            end
            ifa.s_wvalid = 0; ifa.s_wlast = 0;
            chk($sformatf("wrap%0d w_count", r), 64'(ifa.w_count), 64'd10);
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("wrap%0d data %0d", r, i), 64'(ifa.w_rd_data), 64'h200 + 64'(10 * r + i));
                chk($sformatf("wrap%0d last %0d", r, i), 64'(ifa.w_rd_last),
                    (r == 1 && i == 9) ? 64'd1 : 64'd0);
                ifa.w_rd_en = 1;
                tick();
            end
            ifa.w_rd_en = 0;
            chk($sformatf("wrap%0d empty", r), 64'(ifa.w_rd_empty), 64'd1);
        end

        //---------------- reset mid-operation ----------------
        for (int k = 0; k < 7; k++) begin
            ifa.s_awvalid    = (k < 2);
            ifa.s_aw_flat_in = 64'h300 + 64'(k);
            ifa.s_wvalid     = 1;
            ifa.s_w_flat_in  = 37'h400 + 37'(k);
            tick();
        end
        idle_a();
        ifa.b_wr_en = 1; ifa.b_wr_data = 6'd9;
        tick();
        ifa.b_wr_en = 0; ifa.s_bready = 1;
        tick();
        ifa.s_bready = 0; ifa.b_wr_en = 1;
        tick();
        ifa.b_wr_en = 0;
        chk("pre-rst aw_count", 64'(ifa.aw_count), 64'd2);
        chk("pre-rst w_count", 64'(ifa.w_count), 64'd7);
        chk("pre-rst outstanding", 64'(ifa.outstanding), 64'd2);
        chk("pre-rst bvalid", 64'(ifa.s_bvalid), 64'd1);
        reset = 1;
        tick();
        chk("rst aw_count", 64'(ifa.aw_count), 64'd0);
        chk("rst w_count", 64'(ifa.w_count), 64'd0);
        chk("rst outstanding", 64'(ifa.outstanding), 64'd0);
        chk("rst bvalid", 64'(ifa.s_bvalid), 64'd0);
        chk("rst err", 64'(ifa.err_b_overflow), 64'd0);
        chk("rst aw_rd_empty", 64'(ifa.aw_rd_empty), 64'd1);
        chk("rst w_rd_empty", 64'(ifa.w_rd_empty), 64'd1);
        chk("rst awready", 64'(ifa.s_awready), 64'd0);
        chk("rst wready", 64'(ifa.s_wready), 64'd0);
        reset = 0;
        tick();
        chk("post-rst awready", 64'(ifa.s_awready), 64'd1);
        chk("post-rst wready", 64'(ifa.s_wready), 64'd1);

        //---------------- outstanding limit on DUT B (MAX=2) ----------------
        ifb.s_awvalid = 1; ifb.aw_rd_en = 1;
        ifb.s_aw_flat_in = 64'd1;
        tick();
        chk("lim1 outstanding", 64'(ifb.outstanding), 64'd1);
        chk("lim1 awready", 64'(ifb.s_awready), 64'd1);
        ifb.s_aw_flat_in = 64'd2;
        tick();
        chk("lim2 outstanding", 64'(ifb.outstanding), 64'd2);
        chk("lim2 awready", 64'(ifb.s_awready), 64'd0);
        ifb.s_aw_flat_in = 64'd3;
        tick();
        chk("lim3 held outstanding", 64'(ifb.outstanding), 64'd2);
        chk("lim3 aw_count", 64'(ifb.aw_count), 64'd0);
        ifb.b_wr_en = 1; ifb.b_wr_data = 6'd7;
        tick();
        ifb.b_wr_en = 0;
        chk("lim bvalid", 64'(ifb.s_bvalid), 64'd1);
        chk("lim still blocked", 64'(ifb.s_awready), 64'd0);
        ifb.s_bready = 1;
        tick();
        ifb.s_bready = 0;
        chk("lim after B outstanding", 64'(ifb.outstanding), 64'd1);
        chk("lim after B awready", 64'(ifb.s_awready), 64'd1);
        tick();
        ifb.s_awvalid = 0; ifb.aw_rd_en = 0;
        chk("lim 3rd accepted outstanding", 64'(ifb.outstanding), 64'd2);
        chk("lim 3rd data", ifb.aw_rd_data, 64'd3);
        chk("lim 3rd awready", 64'(ifb.s_awready), 64'd0);
        idle_b();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axi4_s_bus_wr_fifos_param
`default_nettype wire

// File: doc/axi4_s_bus_wr_fifos_param.md
Name: axi4_s_bus_wr_fifos_param

Overview:
- Parametrised AXI4 slave write-path buffer: independent AW, W and B FIFOs, each with its own depth, between an AXI4 slave port and a core-side write engine.
- Adds an outstanding-transaction limit on AW acceptance.
- Adds complete-burst tracking (counts buffered WLAST beats), so the core starts a write only when the address and all of its data are present.
- Adds occupancy outputs and a sticky B-overflow error.

Parameters:
AW_W, 64, width of flattened AW payload
W_W, 37, width of flattened W payload excluding WLAST
B_W, 6, width of flattened B payload
AW_DEPTH, 4, AW FIFO entries; power of two, >=2
W_DEPTH, 16, W FIFO entries; power of two, >=2
B_DEPTH, 4, B FIFO entries; power of two, >=2
MAX_OUTSTANDING, 4, max AW accepted without B handshake; 1..255

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_awvalid  in  1  AXI AW valid
s_awready  out  1  AXI AW ready
s_aw_flat_in  in  AW_W  AW payload
s_wvalid  in  1  AXI W valid
s_wready  out  1  AXI W ready
s_w_flat_in  in  W_W  W payload
s_wlast  in  1  AXI WLAST
s_bvalid  out  1  AXI B valid
s_bready  in  1  AXI B ready
s_b_flat_out  out  B_W  B payload
aw_rd_en  in  1  core pops AW head
aw_rd_data  out  AW_W  AW head
aw_rd_empty  out  1  AW FIFO empty
w_rd_en  in  1  core pops W head
w_rd_data  out  W_W  W head payload
w_rd_last  out  1  WLAST of W head
w_rd_empty  out  1  W FIFO empty
burst_ready  out  1  AW head present and at least one complete burst in W FIFO
b_wr_en  in  1  core pushes response
b_wr_data  in  B_W  response payload
b_wr_full  out  1  B FIFO full
aw_count  out  $clog2(AW_DEPTH+1)  AW occupancy
w_count  out  $clog2(W_DEPTH+1)  W occupancy
outstanding  out  8  accepted AW not yet B-handshaked
err_b_overflow  out  1  sticky: b_wr_en while b_wr_full

Behaviour:
- Reset (synchronous, clk rising edge, reset=1):
  - All FIFOs empty; all counters zero; err_b_overflow=0.
  - s_awready=0 and s_wready=0 while reset is high.
  - s_bvalid=0; *_rd_empty=1; burst_ready=0.
  - Reset mid-burst discards all buffered content; there is no drain.
- FIFOs:
  - First-word-fall-through: head data valid whenever empty=0.
  - A push into an empty FIFO is visible at the head the cycle after the push edge (latency 1).
  - A pop takes effect at the edge; the next entry is visible the following cycle.
  - Occupancy counts are registered and update on the same edge.
  - A push when full is ignored, even with a simultaneous pop; there is no full bypass.
  - A pop when empty is ignored with no state change.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- AW channel:
  - s_awready = ~reset & ~aw_full & (outstanding < MAX_OUTSTANDING).
  - Handshake = s_awvalid & s_awready; it pushes s_aw_flat_in.
- W channel:
  - s_wready = ~reset & ~w_full.
  - Handshake pushes {s_wlast, s_w_flat_in}.
  - W may run ahead of AW; AW and W FIFOs are independent.
- B channel:
  - s_bvalid = ~b_empty; s_b_flat_out = B head.
  - Pop on s_bvalid & s_bready.
  - b_wr_en while b_wr_full drops the data and sets err_b_overflow, which stays set until reset.
- outstanding counter:
  - +1 on AW handshake; -1 on B handshake; both in one cycle leaves it unchanged.
  - Never underflows: a B handshake with outstanding=0 is not decremented.
- burst counter (internal, width $clog2(W_DEPTH+1)):
  - +1 on a W handshake with s_wlast=1.
  - -1 on a W pop where the head has w_rd_last=1.
  - Both in one cycle leaves it unchanged.
- burst_ready = ~aw_rd_empty & (burst_cnt != 0); combinational from registered state.
- Core obligations (not checked by this block): pop exactly one AW per burst; pop W beats through the WLAST beat; push one B per burst.

Test Plan:
- Reset then single write: AW then 4 W beats (WLAST on beat 4) -> burst_ready=0 until the edge after beat 4, then 1; w_count=4, aw_count=1; popping 4 W beats plus AW -> burst_ready=0, counts 0.
- Fill: AW_DEPTH=4, MAX_OUTSTANDING=8, 5 AW with no pops -> s_awready=0 after 4th handshake; 5th held; one aw_rd_en -> 5th accepted next cycle, data order preserved.
- Outstanding limit: MAX_OUTSTANDING=2, 3 AW back-to-back with core popping AW -> s_awready low after 2; a B handshake -> outstanding 2->1, s_awready=1 next cycle.
- Simultaneous events: W push with WLAST and W pop of a WLAST head in the same cycle, burst_cnt=1 -> burst_cnt stays 1, w_count unchanged; B push and B pop in the same cycle -> outstanding decrements once.
- Overflow/wrap: fill B FIFO (4 pushes, s_bready=0), 5th b_wr_en -> dropped, err_b_overflow=1 and sticky; drain 4 -> values 1..4 in order; 20 further W beats through W_DEPTH=16 -> pointer wrap, data intact.
- Reset mid-operation: reset with aw_count=2, w_count=7, outstanding=2 -> next cycle all zero, s_bvalid=0, err_b_overflow=0; s_awready/s_wready=1 the cycle after reset deasserts.
